// File: rtl/rv32i_types.sv
// rv32i_types: shared pipeline enums, including the cache/memory arbiter state and grant types
package rv32i_types;
  typedef enum logic [1:0] {IDLE, I_XFER, D_XFER} arb_state_t;
  typedef enum logic {GRANT_I, GRANT_D} arb_grant_t;
endpackage

// File: rtl/cache_mem_arbiter_pick.sv
// cache_mem_arbiter_pick: chooses which cache wins the memory port; ARB_FAIR_EN alternates on contention
module cache_mem_arbiter_pick
  import rv32i_types::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  arb_grant_t last_grant,
  output logic       grant_valid,
  output arb_grant_t grant
);
  assign grant_valid = i_req | d_req;
`ifdef ARB_FAIR_EN
  // D normally wins, but yields to a waiting I right after its own grant
  assign grant = (d_req && !(i_req && last_grant == GRANT_D)) ? GRANT_D : GRANT_I;
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant == GRANT_D;
  assign grant = d_req ? GRANT_D : GRANT_I;
`endif
endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one pmem port between I-cache and D-cache with registered pmem outputs.
// Define ARB_FAIR_EN to alternate grants when both caches contend; otherwise D has fixed priority.
module cache_mem_arbiter
  import rv32i_types::*;
#(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic              arb_busy
);
  arb_state_t        state_q, state_d;
  arb_grant_t        grant, last_grant;
  logic              grant_valid, take;
  logic              read_q, read_d, write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;

  cache_mem_arbiter_pick u_pick (
    .i_req       (i_read),
    .d_req       (d_read | d_write),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  assign take = state_q == IDLE && grant_valid;

`ifdef ARB_FAIR_EN
  arb_grant_t last_grant_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_grant_q <= GRANT_I;
    else if (take) last_grant_q <= grant;
  assign last_grant = last_grant_q;
`else
  assign last_grant = GRANT_I;
`endif

  always_comb begin
    state_d = state_q;
    read_d  = read_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (take) begin
      state_d = grant == GRANT_D ? D_XFER : I_XFER;
      read_d  = grant == GRANT_D ? d_read & ~d_write : 1'b1;
      write_d = grant == GRANT_D && d_write;
      addr_d  = grant == GRANT_D ? d_address : i_address;
      wdata_d = grant == GRANT_D ? d_wdata : wdata_q;
    end else if (state_q != IDLE && pmem_resp) begin
      state_d = IDLE;
      read_d  = 1'b0;
      write_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      read_q  <= read_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign pmem_read    = read_q;
  assign pmem_write   = write_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign arb_busy     = state_q != IDLE;
  assign i_resp       = pmem_resp && state_q == I_XFER;
  assign d_resp       = pmem_resp && state_q == D_XFER;
  assign i_rdata      = pmem_rdata;
  assign d_rdata      = pmem_rdata;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed stimulus with a response scoreboard and a latency-driven memory model
module tb_cache_mem_arbiter;
  localparam int LW = 256;
  localparam int AW = 32;

  typedef struct {
    bit          d;
    logic [LW-1:0] data;
  } exp_t;

  logic          clk = 0, rst_n = 0;
  logic          i_read = 0, d_read = 0, d_write = 0;
  logic [AW-1:0] i_address = '0, d_address = '0;
  logic [LW-1:0] d_wdata = '0;
  logic [LW-1:0] i_rdata, d_rdata, pmem_wdata;
  logic          i_resp, d_resp, pmem_read, pmem_write, arb_busy;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_rdata;
  logic          mem_resp, stray_resp = 0, pmem_resp;
  int            lat = 5, cnt;
  int            errors = 0, checks = 0;
  exp_t          sb[$];

  always #5 clk = ~clk;

  cache_mem_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .arb_busy(arb_busy)
  );

  function automatic logic [LW-1:0] mem_f(input logic [AW-1:0] a);
    return a == 32'h60 ? {32{8'hA5}} : {8{a ^ 32'h5A5A_0000}};
  endfunction

  assign pmem_resp = mem_resp | stray_resp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 0;
      mem_resp <= 1'b0;
      pmem_rdata <= '0;
    end else if (mem_resp) begin
      cnt <= 0;
      mem_resp <= 1'b0;
    end else if (pmem_read || pmem_write) begin
      if (cnt == lat - 1) begin
        mem_resp <= 1'b1;
        pmem_rdata <= mem_f(pmem_address);
      end else cnt <= cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (i_resp || d_resp)) begin
      chk("resp_expected", 1'(sb.size() > 0), 1'b1);
      chk("resp_onehot", 1'(i_resp && d_resp), 1'b0);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_port_d", d_resp, e.d);
        chk("resp_data", e.d ? d_rdata : i_rdata, e.data);
      end
    end
  end

  task automatic wait_resp(input bit any, input bit d, output bit was_d);
    bit seen = 0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      seen = any ? (i_resp || d_resp) : d ? d_resp : i_resp;
    end
    was_d = d_resp;
    chk("resp_arrived", seen, 1'b1);
  endtask

  initial begin
    bit wd;
    repeat (2) @(negedge clk);
    chk("rst_pmem_read", pmem_read, 1'b0);
    chk("rst_pmem_write", pmem_write, 1'b0);
    chk("rst_busy", arb_busy, 1'b0);
    chk("rst_addr", pmem_address, '0);
    chk("rst_wdata", pmem_wdata, '0);
    rst_n = 1;
    @(negedge clk);

    i_read = 1; i_address = 32'h60;
    sb.push_back('{d: 0, data: mem_f(32'h60)});
    @(negedge clk);
    chk("i_pmem_read", pmem_read, 1'b1);
    chk("i_pmem_addr", pmem_address, 32'h60);
    chk("i_busy", arb_busy, 1'b1);
    wait_resp(0, 0, wd);
    i_read = 0;
    @(negedge clk);
    chk("i_resp_1cyc", i_resp, 1'b0);
    chk("i_idle", arb_busy, 1'b0);

    i_read = 1; i_address = 32'h80; d_read = 1; d_address = 32'h400;
    sb.push_back('{d: 1, data: mem_f(32'h400)});
    sb.push_back('{d: 0, data: mem_f(32'h80)});
    @(negedge clk);
    chk("both_d_addr", pmem_address, 32'h400);
    wait_resp(0, 1, wd);
    d_read = 0;
    @(negedge clk);
    chk("both_gap_idle", arb_busy, 1'b0);
    @(negedge clk);
    chk("both_i_addr", pmem_address, 32'h80);
    chk("both_i_read", pmem_read, 1'b1);
    wait_resp(0, 0, wd);
    i_read = 0;
    @(negedge clk);

    d_write = 1; d_address = 32'h1000; d_wdata = {8{32'h1234_5678}};
    sb.push_back('{d: 1, data: mem_f(32'h1000)});
    @(negedge clk);
    chk("w_pmem_write", pmem_write, 1'b1);
    chk("w_pmem_read", pmem_read, 1'b0);
    chk("w_addr", pmem_address, 32'h1000);
    chk("w_wdata", pmem_wdata, {8{32'h1234_5678}});
    wait_resp(0, 1, wd);
    d_write = 0;
    @(negedge clk);
    chk("w_idle", arb_busy, 1'b0);
    chk("w_strobe_clr", pmem_write, 1'b0);

    d_read = 1; d_write = 1; d_address = 32'h1400; d_wdata = {8{32'hCAFE_0001}};
    sb.push_back('{d: 1, data: mem_f(32'h1400)});
    @(negedge clk);
    chk("rw_is_write", {pmem_read, pmem_write}, 2'b01);
    wait_resp(0, 1, wd);
    d_read = 0; d_write = 0;
    @(negedge clk);

    d_read = 1; d_address = 32'h2000;
    sb.push_back('{d: 1, data: mem_f(32'h2000)});
    @(negedge clk);
    d_read = 0;
    repeat (2) @(negedge clk);
    chk("drop_read_held", pmem_read, 1'b1);
    wait_resp(0, 1, wd);
    @(negedge clk);

    d_read = 1; d_address = 32'h3000;
    sb.push_back('{d: 1, data: mem_f(32'h3000)});
    repeat (3) @(negedge clk);
    rst_n = 0;
    #1;
    chk("rstmid_read", pmem_read, 1'b0);
    chk("rstmid_busy", arb_busy, 1'b0);
    sb.delete();
    d_read = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    stray_resp = 1;
    #1;
    chk("stray_d_resp", d_resp, 1'b0);
    chk("stray_i_resp", i_resp, 1'b0);
    @(negedge clk);
    stray_resp = 0;
    @(negedge clk);
    chk("stray_idle", arb_busy, 1'b0);

`ifdef ARB_FAIR_EN
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    d_read = 1; d_address = 32'h4000; i_read = 1; i_address = 32'h5000;
    for (int k = 0; k < 4; k++)
      sb.push_back('{d: k % 2 == 0, data: mem_f(k % 2 == 0 ? 32'h4000 : 32'h5000)});
    for (int k = 0; k < 4; k++) begin
      wait_resp(1, 0, wd);
      chk("fair_order_d", wd, 1'(k % 2 == 0));
    end
    d_read = 0; i_read = 0;
    @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
